weight_buffer: RTL and testbench
================================

# weight_buffer

Double-banked (ping-pong) weight store feeding the systolic array's weight-load path; next generation of the single-bank weight memory. A host writes one SIZE×SIZE weight tile into the fill bank while the array streams the previously committed tile out of the drain bank, one column vector per cycle. Width, tile size and the zero-weight lane flag are parametrised or configurable.

## Interface
- SIZE, 8, array dimension; tile holds SIZE*SIZE weights
- WEIGHT_WIDTH, 5, bits per weight
- WR_ADDR_WIDTH, $clog2(SIZE*SIZE), write address width (derived)
- COL_WIDTH, $clog2(SIZE), column counter width (derived)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- Wr_en  in  1  write one weight into fill bank
- Wr_Addr  in  WR_ADDR_WIDTH  row-major index: row*SIZE+col
- Weight_Data  in  WEIGHT_WIDTH  weight to write
- Wr_Done  in  1  commit fill bank (mark full, swap fill pointer)
- Wr_Full  out  1  fill bank full; writes and Wr_Done ignored
- Rd_Start  in  1  request stream of drain bank
- Rd_Avail  out  1  drain bank full and FSM idle
- Weight_out  out  SIZE*WEIGHT_WIDTH  lane k = weight[row k][col c]
- Weight_Valid  out  1  Weight_out valid this cycle
- Rd_Last  out  1  high with column SIZE-1
- Zero_Mask  out  SIZE  only with WB_ZERO_MASK_EN

## Operation
- State: full[1:0], fill_sel, drain_sel, FSM {IDLE, STREAM}, col counter.
- Write: Wr_en && !full[fill_sel] → bank[fill_sel][Wr_Addr] <= Weight_Data. When full, write dropped silently.
- Commit: Wr_Done && !full[fill_sel] → full[fill_sel]<=1, fill_sel toggles. Wr_en and Wr_Done in same cycle: write lands in old fill bank, then commit.
- Wr_Full = full[fill_sel]; Rd_Avail = (state==IDLE) && full[drain_sel].
- IDLE: Rd_Start && full[drain_sel] → read column 0, col<=1, go STREAM (if SIZE==1 treat as last). Otherwise Rd_Start ignored.
- STREAM: read column col each cycle, col++. On reading column SIZE-1: full[drain_sel]<=0, drain_sel toggles, col<=0, go IDLE.
- Rd_Start in STREAM ignored.
- Column read: Weight_out[k*W +: W] <= bank[drain_sel][k*SIZE+c] for all k; Weight_Valid<=1; Rd_Last<=(c==SIZE-1). Idle cycles: Weight_Valid<=0, Rd_Last<=0, Weight_out holds.
- Fill and drain banks never coincide (writes need full[fill]=0, streaming needs full[drain]=1); commit and stream-end same cycle update independent bits.
- Write address ≥ SIZE*SIZE (non-power-of-two SIZE): write dropped.

## Timing
- Reset: full=0, fill_sel=drain_sel=0, IDLE, col=0, Weight_out=0, Weight_Valid=0, Rd_Last=0, Zero_Mask=0. Memory contents not reset.
- Rd_Start sampled at edge T → Weight_Valid high cycles T+1..T+SIZE, Rd_Last at T+SIZE.
- FSM is IDLE during last valid cycle: Rd_Start there (with other bank full) gives gapless back-to-back tiles.
- Commit at edge T → Rd_Avail high from T+1 (if idle); Wr_Full updates at T+1.
- Reset mid-stream: Weight_Valid drops immediately (async), both banks empty.

## Configuration
- WB_ZERO_MASK_EN defined: Zero_Mask port present; bit k registered with Weight_out, 1 when lane k weight == 0; 0 when idle. Used by PEs for zero-skip power gating.
- Not defined: port and logic absent; all else identical.

## Structure
- Package weight_buffer_pkg: FSM state typedef (IDLE, STREAM), bank-select typedef, width localparam helpers.
- Sub-module weight_bank: one SIZE*SIZE×WEIGHT_WIDTH array, write port plus column-vector read; instantiated twice, top holds FSM, pointers, output mux/registers.

## Test plan
- Fill bank 0 with weight=(row*8+col)%32, Wr_Done, Rd_Start → 8 valid cycles, column c lane k = (k*8+c)%32, Rd_Last on 8th, full cleared.
- Fill and commit both banks; third Wr_en of 7 at addr 0 → dropped, Wr_Full=1; stream both → second tile intact.
- Rd_Start on Rd_Avail=0 cycle before commit → no Weight_Valid; after commit accepted normally.
- Both banks full, Rd_Start in last valid cycle of tile A → tile B starts next cycle, 16 consecutive valid cycles.
- Wr_en+Wr_Done same cycle at addr 63 → value present as lane 7 of column 7 when streamed.
- rst_n low at 4th valid cycle → outputs 0 immediately, Rd_Avail=0, Wr_Full=0; WB_ZERO_MASK_EN build: tile with row 3 zeros → Zero_Mask=8'b0000_1000 every column.

Source files
------------

// File: rtl/weight_buffer_pkg.sv
// Shared types and width helpers for the ping-pong weight buffer.
// Optional zero-lane flag output is enabled with WB_ZERO_MASK_EN.
package weight_buffer_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  typedef logic bank_sel_t;

  // Index width that never collapses to zero bits for degenerate sizes.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/weight_bank.sv
// One SIZE x SIZE weight tile: single write port, combinational column-vector read.
// The read is registered by the parent, so the pair maps onto RAM with registered output.
module weight_bank
  import weight_buffer_pkg::*;
#(
  parameter int SIZE         = 8,
  parameter int WEIGHT_WIDTH = 5,
  parameter int ADDR_WIDTH   = idx_width(SIZE * SIZE),
  parameter int COL_WIDTH    = idx_width(SIZE)
) (
  input  logic                         clk,
  input  logic                         i_wr_en,
  input  logic [ADDR_WIDTH-1:0]        i_wr_addr,
  input  logic [WEIGHT_WIDTH-1:0]      i_wr_data,
  input  logic [COL_WIDTH-1:0]         i_rd_col,
  output logic [SIZE*WEIGHT_WIDTH-1:0] o_rd_vec
);

  logic [WEIGHT_WIDTH-1:0] r_mem [SIZE*SIZE];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Lane k of the column vector is row k of the selected column (row-major storage).
  genvar gi;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_lane
      logic [ADDR_WIDTH-1:0] w_idx;
      assign w_idx = ADDR_WIDTH'(gi * SIZE) + ADDR_WIDTH'(i_rd_col);
      assign o_rd_vec[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH] = r_mem[w_idx];
    end
  endgenerate

endmodule

// File: rtl/weight_buffer.sv
// Ping-pong weight store: host fills one bank while the array drains the other column by column.
// Define WB_ZERO_MASK_EN to add the per-lane Zero_Mask output for PE zero-skip gating.
module weight_buffer
  import weight_buffer_pkg::*;
#(
  parameter int SIZE          = 8,
  parameter int WEIGHT_WIDTH  = 5,
  parameter int WR_ADDR_WIDTH = idx_width(SIZE * SIZE),
  parameter int COL_WIDTH     = idx_width(SIZE)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         Wr_en,
  input  logic [WR_ADDR_WIDTH-1:0]     Wr_Addr,
  input  logic [WEIGHT_WIDTH-1:0]      Weight_Data,
  input  logic                         Wr_Done,
  output logic                         Wr_Full,
  input  logic                         Rd_Start,
  output logic                         Rd_Avail,
  output logic [SIZE*WEIGHT_WIDTH-1:0] Weight_out,
  output logic                         Weight_Valid,
  output logic                         Rd_Last
`ifdef WB_ZERO_MASK_EN
  ,
  output logic [SIZE-1:0]              Zero_Mask
`endif
);

  state_t                       r_state, w_state_next;
  logic [COL_WIDTH-1:0]         r_col, w_col_next, w_rd_col;
  logic [1:0]                   r_full, w_full_next;
  bank_sel_t                    r_fill_sel, w_fill_sel_next;
  bank_sel_t                    r_drain_sel, w_drain_sel_next;
  logic                         w_addr_ok, w_wr_accept, w_commit, w_read, w_last;
  logic [SIZE*WEIGHT_WIDTH-1:0] w_bank_vec [2];
  logic [SIZE*WEIGHT_WIDTH-1:0] w_drain_vec;
  logic [SIZE*WEIGHT_WIDTH-1:0] r_weight_out;
  logic                         r_valid, r_last;

  generate
    if (SIZE * SIZE == (1 << WR_ADDR_WIDTH)) begin : g_addr_all
      assign w_addr_ok = 1'b1;
    end else begin : g_addr_chk
      assign w_addr_ok = (Wr_Addr < WR_ADDR_WIDTH'(SIZE * SIZE));
    end
  endgenerate

  assign w_wr_accept = Wr_en && !r_full[r_fill_sel] && w_addr_ok;
  assign w_commit    = Wr_Done && !r_full[r_fill_sel];
  assign w_rd_col    = (r_state == STREAM) ? r_col : '0;
  assign w_read      = (r_state == STREAM) || (Rd_Start && r_full[r_drain_sel]);
  assign w_last      = w_read && (w_rd_col == COL_WIDTH'(SIZE - 1));
  assign w_drain_vec = w_bank_vec[r_drain_sel];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      weight_bank #(
        .SIZE        (SIZE),
        .WEIGHT_WIDTH(WEIGHT_WIDTH),
        .ADDR_WIDTH  (WR_ADDR_WIDTH),
        .COL_WIDTH   (COL_WIDTH)
      ) u_bank (
        .clk      (clk),
        .i_wr_en  (w_wr_accept && (r_fill_sel == bank_sel_t'(gi))),
        .i_wr_addr(Wr_Addr),
        .i_wr_data(Weight_Data),
        .i_rd_col (w_rd_col),
        .o_rd_vec (w_bank_vec[gi])
      );
    end
  endgenerate

  // Commit and end-of-stream touch different full bits: fill needs full=0, drain needs full=1.
  always_comb begin
    w_state_next     = r_state;
    w_col_next       = r_col;
    w_full_next      = r_full;
    w_fill_sel_next  = r_fill_sel;
    w_drain_sel_next = r_drain_sel;
    if (w_commit) begin
      w_full_next[r_fill_sel] = 1'b1;
      w_fill_sel_next         = ~r_fill_sel;
    end
    if (w_read) begin
      if (w_last) begin
        w_full_next[r_drain_sel] = 1'b0;
        w_drain_sel_next         = ~r_drain_sel;
        w_col_next               = '0;
        w_state_next             = IDLE;
      end else begin
        w_col_next   = w_rd_col + COL_WIDTH'(1);
        w_state_next = STREAM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_col       <= '0;
      r_full      <= '0;
      r_fill_sel  <= '0;
      r_drain_sel <= '0;
    end else begin
      r_state     <= w_state_next;
      r_col       <= w_col_next;
      r_full      <= w_full_next;
      r_fill_sel  <= w_fill_sel_next;
      r_drain_sel <= w_drain_sel_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_weight_out <= '0;
      r_valid      <= 1'b0;
      r_last       <= 1'b0;
    end else begin
      r_valid <= w_read;
      r_last  <= w_last;
      if (w_read) begin
        r_weight_out <= w_drain_vec;
      end
    end
  end

`ifdef WB_ZERO_MASK_EN
  logic [SIZE-1:0] w_zero_vec;
  logic [SIZE-1:0] r_zero_mask;

  for (gi = 0; gi < SIZE; gi++) begin : g_zero
    assign w_zero_vec[gi] = (w_drain_vec[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH] == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero_mask <= '0;
    end else begin
      r_zero_mask <= w_read ? w_zero_vec : '0;
    end
  end

  assign Zero_Mask = r_zero_mask;
`endif

  assign Wr_Full      = r_full[r_fill_sel];
  assign Rd_Avail     = (r_state == IDLE) && r_full[r_drain_sel];
  assign Weight_out   = r_weight_out;
  assign Weight_Valid = r_valid;
  assign Rd_Last      = r_last;

endmodule

// File: tb/tb_weight_buffer.sv
// Directed bench for weight_buffer (SIZE=8, 5-bit weights); build with WB_ZERO_MASK_EN to also check Zero_Mask.
module tb_weight_buffer;

  localparam int SIZE = 8;
  localparam int W    = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        Wr_en = 1'b0;
  logic [5:0]  Wr_Addr = '0;
  logic [4:0]  Weight_Data = '0;
  logic        Wr_Done = 1'b0;
  logic        Rd_Start = 1'b0;
  logic        Wr_Full, Rd_Avail, Weight_Valid, Rd_Last;
  logic [39:0] Weight_out;
`ifdef WB_ZERO_MASK_EN
  logic [7:0]  Zero_Mask;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  weight_buffer #(.SIZE(SIZE), .WEIGHT_WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Wr_en       (Wr_en),
    .Wr_Addr     (Wr_Addr),
    .Weight_Data (Weight_Data),
    .Wr_Done     (Wr_Done),
    .Wr_Full     (Wr_Full),
    .Rd_Start    (Rd_Start),
    .Rd_Avail    (Rd_Avail),
    .Weight_out  (Weight_out),
    .Weight_Valid(Weight_Valid),
    .Rd_Last     (Rd_Last)
`ifdef WB_ZERO_MASK_EN
    ,
    .Zero_Mask   (Zero_Mask)
`endif
  );

  typedef struct {
    string       name;
    bit          rd_start;
    bit          wr_done;
    bit          e_full;
    bit          e_avail;
    bit          e_valid;
    bit          e_last;
    logic [39:0] e_out;
  } vec_t;

  vec_t vecs[12];

  // Tile patterns; address a = row*8 + col.
  function automatic logic [4:0] pat_val(input int pat, input int a);
    int r;
    r = a / 8;
    case (pat)
      0:       return 5'(a % 32);
      1:       return 5'((a * 3 + 1) % 32);
      2:       return 5'(31 - (a % 32));
      3:       return (a == 63) ? 5'd17 : 5'((a + 5) % 32);
      default: return (r == 3) ? 5'd0 : 5'((a % 31) + 1);
    endcase
  endfunction

  function automatic logic [39:0] col_vec(input int pat, input int c);
    logic [39:0] v;
    v = '0;
    for (int k = 0; k < SIZE; k++) v[k*W +: W] = pat_val(pat, k * 8 + c);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    Wr_en    = 1'b0;
    Wr_Done  = 1'b0;
    Rd_Start = 1'b0;
  endtask

  task automatic fill_tile(input int pat, input bit done_on_last);
    for (int a = 0; a < 64; a++) begin
      Wr_en       = 1'b1;
      Wr_Addr     = 6'(a);
      Weight_Data = pat_val(pat, a);
      Wr_Done     = done_on_last && (a == 63);
      @(negedge clk);
    end
    idle_inputs();
    $display("fill pattern %0d done_on_last=%0b", pat, done_on_last);
  endtask

  task automatic commit();
    Wr_Done = 1'b1;
    @(negedge clk);
    Wr_Done = 1'b0;
    $display("commit: Wr_Full=%0b Rd_Avail=%0b", Wr_Full, Rd_Avail);
  endtask

  task automatic stream_check(input int pat, input bit check_mask);
    Rd_Start = 1'b1;
    @(negedge clk);
    Rd_Start = 1'b0;
    for (int c = 0; c < SIZE; c++) begin
      chk($sformatf("p%0d_c%0d_valid", pat, c), Weight_Valid, 1'b1);
      chk($sformatf("p%0d_c%0d_last", pat, c), Rd_Last, (c == SIZE - 1));
      chk($sformatf("p%0d_c%0d_out", pat, c), Weight_out, col_vec(pat, c));
`ifdef WB_ZERO_MASK_EN
      if (check_mask) chk($sformatf("p%0d_c%0d_mask", pat, c), Zero_Mask, 8'b0000_1000);
`endif
      $display("stream pat %0d col %0d out=%h last=%0b", pat, c, Weight_out, Rd_Last);
      @(negedge clk);
    end
    chk($sformatf("p%0d_after_valid", pat), Weight_Valid, 1'b0);
    chk($sformatf("p%0d_after_last", pat), Rd_Last, 1'b0);
`ifdef WB_ZERO_MASK_EN
    chk($sformatf("p%0d_after_mask", pat), Zero_Mask, 8'h00);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Control-sequence table for the first tile (bank 0 filled, not yet committed).
    vecs[0] = '{"start_uncommitted", 1, 0, 0, 0, 0, 0, 40'h0};
    vecs[1] = '{"commit_bank0",      0, 1, 0, 1, 0, 0, 40'h0};
    vecs[2] = '{"start_bank0",       1, 0, 0, 0, 1, 0, col_vec(0, 0)};
    for (int c = 1; c < SIZE; c++)
      vecs[2 + c] = '{$sformatf("col%0d", c), (c == 3), 0, 0, 0, 1, (c == 7), col_vec(0, c)};
    vecs[10] = '{"idle_hold",   0, 0, 0, 0, 0, 0, col_vec(0, 7)};
    vecs[11] = '{"start_empty", 1, 0, 0, 0, 0, 0, col_vec(0, 7)};

    // Reset state
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", Weight_Valid, 1'b0);
    chk("rst_last", Rd_Last, 1'b0);
    chk("rst_out", Weight_out, 40'h0);
    chk("rst_full", Wr_Full, 1'b0);
    chk("rst_avail", Rd_Avail, 1'b0);
`ifdef WB_ZERO_MASK_EN
    chk("rst_mask", Zero_Mask, 8'h00);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Tile 1: (row*8+col)%32, start before commit is ignored
    fill_tile(0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      Rd_Start = vecs[i].rd_start;
      Wr_Done  = vecs[i].wr_done;
      @(negedge clk);
      chk({vecs[i].name, ".full"},  Wr_Full,      vecs[i].e_full);
      chk({vecs[i].name, ".avail"}, Rd_Avail,     vecs[i].e_avail);
      chk({vecs[i].name, ".valid"}, Weight_Valid, vecs[i].e_valid);
      chk({vecs[i].name, ".last"},  Rd_Last,      vecs[i].e_last);
      chk({vecs[i].name, ".out"},   Weight_out,   vecs[i].e_out);
      $display("vec %0d %s valid=%0b last=%0b out=%h", i, vecs[i].name, Weight_Valid, Rd_Last, Weight_out);
    end
    idle_inputs();

    // Both banks full, dropped write, back-to-back streaming
    fill_tile(1, 1'b0);
    commit();
    chk("b1_commit_full", Wr_Full, 1'b0);
    chk("b1_commit_avail", Rd_Avail, 1'b1);
    fill_tile(2, 1'b0);
    commit();
    chk("both_full", Wr_Full, 1'b1);
    chk("both_avail", Rd_Avail, 1'b1);
    Wr_en = 1'b1; Wr_Addr = 6'd0; Weight_Data = 5'd7; Wr_Done = 1'b1;
    @(negedge clk);
    idle_inputs();
    chk("drop_full", Wr_Full, 1'b1);
    $display("dropped write addr 0 data 7, Wr_Full=%0b", Wr_Full);

    Rd_Start = 1'b1;
    @(negedge clk);
    Rd_Start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("b2b_%0d_valid", i), Weight_Valid, 1'b1);
      chk($sformatf("b2b_%0d_last", i), Rd_Last, ((i % 8) == 7));
      chk($sformatf("b2b_%0d_out", i), Weight_out, col_vec((i < 8) ? 1 : 2, i % 8));
      if (i == 7) chk("b2b_avail_last_a", Rd_Avail, 1'b1);
      $display("b2b cycle %0d out=%h last=%0b", i, Weight_out, Rd_Last);
      Rd_Start = (i == 7) || (i == 3);
      @(negedge clk);
      Rd_Start = 1'b0;
    end
    chk("b2b_end_valid", Weight_Valid, 1'b0);
    chk("b2b_end_avail", Rd_Avail, 1'b0);
    chk("b2b_end_full", Wr_Full, 1'b0);

    // Write and commit in the same cycle at address 63
    fill_tile(3, 1'b1);
    chk("wd63_avail", Rd_Avail, 1'b1);
    stream_check(3, 1'b0);

    // Reset during the 4th valid cycle with both banks full
    fill_tile(4, 1'b1);
    fill_tile(1, 1'b1);
    chk("pre_rst_full", Wr_Full, 1'b1);
    Rd_Start = 1'b1;
    @(negedge clk);
    Rd_Start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("mr_c%0d_out", c), Weight_out, col_vec(4, c));
      @(negedge clk);
    end
    chk("mr_4th_valid", Weight_Valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", Weight_Valid, 1'b0);
    chk("mr_last", Rd_Last, 1'b0);
    chk("mr_out", Weight_out, 40'h0);
    chk("mr_avail", Rd_Avail, 1'b0);
    chk("mr_full", Wr_Full, 1'b0);
`ifdef WB_ZERO_MASK_EN
    chk("mr_mask", Zero_Mask, 8'h00);
`endif
    $display("reset mid-stream: valid=%0b out=%h", Weight_Valid, Weight_out);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", Weight_Valid, 1'b0);

    // Re-commit bank 0 (contents untouched by reset) and stream with zero-row mask
    commit();
    chk("recommit_avail", Rd_Avail, 1'b1);
    stream_check(4, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
